// File: rtl/reg_hold_arb_pkg.sv
// Shared types and helpers for the multi-channel holding-register arbiter.
package reg_hold_arb_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  typedef struct packed {
    logic we;
    logic re;
    logic regwen;
  } txn_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/reg_hold_rr_pick.sv
// Combinational round-robin pick: first pending channel strictly after the pointer.
module reg_hold_rr_pick #(
  parameter int unsigned NumRegs  = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumRegs-1:0]  i_pend,
  input  logic [IdxWidth-1:0] i_ptr,
  output logic                o_valid,
  output logic [IdxWidth-1:0] o_idx
);

  always_comb begin
    int unsigned w_c;
    logic [IdxWidth-1:0] w_ci;
    o_valid = 1'b0;
    o_idx   = '0;
    w_c     = 0;
    w_ci    = '0;
    for (int unsigned k = 1; k <= NumRegs; k++) begin
      w_c  = (32'(i_ptr) + k) % NumRegs;
      w_ci = IdxWidth'(w_c);
      if (!o_valid && i_pend[w_ci]) begin
        o_valid = 1'b1;
        o_idx   = w_ci;
      end
    end
  end

endmodule

// File: rtl/reg_hold_arb.sv
// Per-channel holding registers with busy tracking, serialised round-robin onto
// a single req/ack downstream register port with optional ack timeout.
module reg_hold_arb
  import reg_hold_arb_pkg::*;
#(
  parameter int unsigned                   NumRegs    = 4,
  parameter int unsigned                   DataWidth  = 32,
  parameter logic [NumRegs*DataWidth-1:0]  ResetVal   = '0,
  parameter logic [NumRegs*DataWidth-1:0]  BitMask    = '1,
  parameter int unsigned                   AckTimeout = 0,
  parameter int unsigned                   IdxWidth   = idx_width(NumRegs)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumRegs-1:0]             src_we_i,
  input  logic [NumRegs-1:0]             src_re_i,
  input  logic [NumRegs-1:0]             src_regwen_i,
  input  logic [NumRegs*DataWidth-1:0]   src_wd_i,
  output logic [NumRegs-1:0]             src_busy_o,
  output logic [NumRegs*DataWidth-1:0]   src_qs_o,
  output logic [NumRegs-1:0]             src_err_o,
  output logic                           dst_req_o,
  output logic [IdxWidth-1:0]            dst_idx_o,
  output logic                           dst_we_o,
  output logic                           dst_re_o,
  output logic                           dst_regwen_o,
  output logic [DataWidth-1:0]           dst_wd_o,
  input  logic                           dst_ack_i,
  input  logic [DataWidth-1:0]           dst_qs_i,
  input  logic [NumRegs-1:0]             dst_update_i,
  input  logic [NumRegs*DataWidth-1:0]   dst_ds_i
);

  localparam int unsigned CntWidth = idx_width(AckTimeout + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(AckTimeout - 1);
  localparam logic [NumRegs-1:0][DataWidth-1:0] Mask = BitMask;
  localparam logic [NumRegs-1:0][DataWidth-1:0] RstQ = ResetVal;

  state_e                              r_state, w_state_n;
  logic [IdxWidth-1:0]                 r_idx, r_ptr, w_pick_idx;
  logic                                w_pick_valid;
  logic [NumRegs-1:0]                  w_req, w_cap;
  logic [NumRegs-1:0]                  r_busy, r_pend, r_err;
  txn_t [NumRegs-1:0]                  r_txn;
  logic [NumRegs-1:0][DataWidth-1:0]   r_src_q;
  logic [CntWidth-1:0]                 r_cnt;
  logic                                w_grant, w_done, w_abort;
  txn_t                                w_cur_txn;
  logic [DataWidth-1:0]                w_cur_q;

  // A request on a busy channel is dropped outright.
  assign w_req = src_we_i | src_re_i;
  assign w_cap = w_req & ~r_busy;

  reg_hold_rr_pick #(
    .NumRegs (NumRegs),
    .IdxWidth(IdxWidth)
  ) u_pick (
    .i_pend (r_pend),
    .i_ptr  (r_ptr),
    .o_valid(w_pick_valid),
    .o_idx  (w_pick_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_grant   = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    dst_req_o = 1'b0;
    w_cur_txn = '0;
    w_cur_q   = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant   = 1'b1;
          w_state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        dst_req_o = 1'b1;
        w_cur_txn = r_txn[r_idx];
        w_cur_q   = r_src_q[r_idx];
        // Ack takes priority over a timeout expiring in the same cycle.
        if (dst_ack_i) begin
          w_done    = 1'b1;
          w_state_n = IDLE;
        end else if (AckTimeout != 0 && r_cnt == CntLast) begin
          w_abort   = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign dst_idx_o    = r_idx;
  assign dst_we_o     = w_cur_txn.we;
  assign dst_re_o     = w_cur_txn.re;
  assign dst_regwen_o = w_cur_txn.regwen;
  assign dst_wd_o     = w_cur_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_src_q <= RstQ;
      r_txn   <= '0;
      r_busy  <= '0;
      r_pend  <= '0;
      r_err   <= '0;
      r_idx   <= '0;
      r_ptr   <= IdxWidth'(NumRegs - 1);
      r_cnt   <= '0;
    end else begin
      r_err <= '0;
      if (w_grant) begin
        r_idx <= w_pick_idx;
        r_ptr <= w_pick_idx;
        r_cnt <= '0;
      end else if (r_state == ACTIVE) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end
      for (int unsigned i = 0; i < NumRegs; i++) begin
        if (w_cap[i]) begin
          r_src_q[i] <= src_wd_i[i*DataWidth +: DataWidth] & Mask[i];
          r_txn[i]   <= {src_we_i[i], src_re_i[i], src_regwen_i[i]};
          r_busy[i]  <= 1'b1;
          r_pend[i]  <= 1'b1;
        end else begin
          if (w_grant && w_pick_idx == IdxWidth'(i)) r_pend[i] <= 1'b0;
          if ((w_done || w_abort) && r_idx == IdxWidth'(i)) begin
            r_txn[i]  <= '0;
            r_busy[i] <= 1'b0;
          end
          // Ack data beats a same-cycle hardware update; updates skip busy channels.
          if (w_done && r_idx == IdxWidth'(i))
            r_src_q[i] <= dst_qs_i & Mask[i];
          else if (dst_update_i[i] && !r_busy[i])
            r_src_q[i] <= dst_ds_i[i*DataWidth +: DataWidth] & Mask[i];
          if (w_abort && r_idx == IdxWidth'(i)) r_err[i] <= 1'b1;
        end
      end
    end
  end

  assign src_busy_o = r_busy;
  assign src_qs_o   = r_src_q;
  assign src_err_o  = r_err;

  a_no_req_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_req & r_busy) == '0);
  a_ack_with_req: assert property (@(posedge clk_i) disable iff (rst_i)
    dst_ack_i |-> dst_req_o);
  a_dst_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({dst_req_o, dst_idx_o, dst_we_o, dst_re_o, dst_regwen_o, dst_wd_o}));
  a_pend_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_pend & ~r_busy) == '0);
  a_active_one: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == ACTIVE) |-> (r_busy[r_idx] && !r_pend[r_idx]));

endmodule

// File: tb/tb_reg_hold_arb.sv
// Directed bench for reg_hold_arb: vector table plus multi-cycle sequences.
module tb_reg_hold_arb;

  localparam logic [127:0] RV = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] BM = {32'h00FF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   src_we_i = '0, src_re_i = '0, src_regwen_i = '0;
  logic [127:0] src_wd_i = '0;
  logic [3:0]   src_busy_o, src_err_o;
  logic [127:0] src_qs_o;
  logic         dst_req_o, dst_we_o, dst_re_o, dst_regwen_o;
  logic [1:0]   dst_idx_o;
  logic [31:0]  dst_wd_o;
  logic         dst_ack_i = 1'b0;
  logic [31:0]  dst_qs_i = '0;
  logic [3:0]   dst_update_i = '0;
  logic [127:0] dst_ds_i = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  reg_hold_arb #(
    .NumRegs   (4),
    .DataWidth (32),
    .ResetVal  (RV),
    .BitMask   (BM),
    .AckTimeout(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .src_we_i    (src_we_i),
    .src_re_i    (src_re_i),
    .src_regwen_i(src_regwen_i),
    .src_wd_i    (src_wd_i),
    .src_busy_o  (src_busy_o),
    .src_qs_o    (src_qs_o),
    .src_err_o   (src_err_o),
    .dst_req_o   (dst_req_o),
    .dst_idx_o   (dst_idx_o),
    .dst_we_o    (dst_we_o),
    .dst_re_o    (dst_re_o),
    .dst_regwen_o(dst_regwen_o),
    .dst_wd_o    (dst_wd_o),
    .dst_ack_i   (dst_ack_i),
    .dst_qs_i    (dst_qs_i),
    .dst_update_i(dst_update_i),
    .dst_ds_i    (dst_ds_i)
  );

  typedef struct {
    int unsigned ch;
    logic [2:0]  txn;
    logic [31:0] wd;
    logic [31:0] qs;
    logic [31:0] exp_wd;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!dst_req_o && n < 16) begin
      step();
      n++;
    end
    check({name, " req"}, 128'(dst_req_o), 128'(1));
  endtask

  function automatic logic [31:0] qs_of(input int unsigned ch);
    return src_qs_o[ch*32 +: 32];
  endfunction

  task automatic request(input int unsigned ch, input logic [2:0] t, input logic [31:0] wd);
    src_we_i[ch]           = t[2];
    src_re_i[ch]           = t[1];
    src_regwen_i[ch]       = t[0];
    src_wd_i[ch*32 +: 32]  = wd;
  endtask

  task automatic clear_req();
    src_we_i     = '0;
    src_re_i     = '0;
    src_regwen_i = '0;
  endtask

  initial begin
    int unsigned exp_order[4];
    int          n;

    vecs[0] = '{0, 3'b101, 32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001};
    vecs[1] = '{1, 3'b010, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D};
    vecs[2] = '{3, 3'b100, 32'hFFFF_FFFF, 32'h1234_5678, 32'h00FF_FFFF, 32'h0034_5678};
    vecs[3] = '{2, 3'b111, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
    vecs[4] = '{3, 3'b011, 32'hABCD_EF01, 32'hFFFF_FFFF, 32'h00CD_EF01, 32'h00FF_FFFF};

    repeat (2) step();
    rst_i = 1'b0;
    step();
    check("rst qs", src_qs_o, RV);
    check("rst busy", 128'(src_busy_o), 128'(0));
    check("rst err", 128'(src_err_o), 128'(0));
    check("rst req", 128'(dst_req_o), 128'(0));
    check("rst wd", 128'(dst_wd_o), 128'(0));

    // Single write, exact latency
    request(2, 3'b100, 32'hDEAD_BEEF);
    step();
    clear_req();
    check("sw busy c1", 128'(src_busy_o[2]), 128'(1));
    check("sw req c1", 128'(dst_req_o), 128'(0));
    step();
    check("sw req c2", 128'(dst_req_o), 128'(1));
    check("sw idx", 128'(dst_idx_o), 128'(2));
    check("sw txn", 128'({dst_we_o, dst_re_o, dst_regwen_o}), 128'(3'b100));
    check("sw wd", 128'(dst_wd_o), 128'(32'hDEAD_BEEF));
    step();
    step();
    dst_ack_i = 1'b1;
    dst_qs_i  = 32'hDEAD_BEEF;
    step();
    dst_ack_i = 1'b0;
    check("sw busy c5", 128'(src_busy_o[2]), 128'(0));
    check("sw qs c5", 128'(qs_of(2)), 128'(32'hDEAD_BEEF));

    // Table of single transactions
    for (int v = 0; v < 5; v++) begin
      request(vecs[v].ch, vecs[v].txn, vecs[v].wd);
      step();
      clear_req();
      wait_req($sformatf("vec%0d", v));
      check($sformatf("vec%0d idx", v), 128'(dst_idx_o), 128'(vecs[v].ch));
      check($sformatf("vec%0d txn", v), 128'({dst_we_o, dst_re_o, dst_regwen_o}), 128'(vecs[v].txn));
      check($sformatf("vec%0d wd", v), 128'(dst_wd_o), 128'(vecs[v].exp_wd));
      dst_ack_i = 1'b1;
      dst_qs_i  = vecs[v].qs;
      step();
      dst_ack_i = 1'b0;
      check($sformatf("vec%0d busy", v), 128'(src_busy_o), 128'(0));
      check($sformatf("vec%0d qs", v), 128'(qs_of(vecs[v].ch)), 128'(vecs[v].exp_q));
      check($sformatf("vec%0d idle we", v), 128'({dst_req_o, dst_we_o, dst_wd_o}), 128'(0));
    end

    // Round-robin with a late re-request on channel 0
    exp_order = '{0, 1, 3, 0};
    request(0, 3'b100, 32'h0000_00C0);
    request(1, 3'b100, 32'h0000_00C1);
    request(3, 3'b100, 32'h0000_00C3);
    step();
    clear_req();
    for (int k = 0; k < 4; k++) begin
      wait_req($sformatf("rr%0d", k));
      check($sformatf("rr%0d idx", k), 128'(dst_idx_o), 128'(exp_order[k]));
      if (k == 1) request(0, 3'b101, 32'h0000_00D0);
      step();
      clear_req();
      dst_ack_i = 1'b1;
      dst_qs_i  = 32'h0000_0100 + 32'(k);
      step();
      dst_ack_i = 1'b0;
    end
    check("rr busy", 128'(src_busy_o), 128'(0));
    check("rr qs0", 128'(qs_of(0)), 128'(32'h0000_0103));

    // Update while busy is ignored; ack then idle update apply
    request(1, 3'b100, 32'h0000_0001);
    step();
    clear_req();
    dst_update_i[1] = 1'b1;
    dst_ds_i[63:32] = 32'h55;
    step();
    dst_update_i = '0;
    check("cf busy upd", 128'(qs_of(1)), 128'(32'h1));
    wait_req("cf");
    dst_ack_i = 1'b1;
    dst_qs_i  = 32'hAA;
    step();
    dst_ack_i = 1'b0;
    check("cf ack qs", 128'(qs_of(1)), 128'(32'hAA));
    dst_update_i[1] = 1'b1;
    step();
    dst_update_i = '0;
    check("cf idle upd", 128'(qs_of(1)), 128'(32'h55));

    // Ack/update collision on channel 0, concurrent update on idle channel 2
    request(0, 3'b100, 32'h99);
    step();
    clear_req();
    wait_req("col");
    dst_update_i      = 4'b0100;
    dst_ds_i[95:64]   = 32'h77;
    step();
    dst_update_i      = '0;
    check("col ch2 upd", 128'(qs_of(2)), 128'(32'h77));
    dst_ack_i         = 1'b1;
    dst_qs_i          = 32'h11;
    dst_update_i      = 4'b0001;
    dst_ds_i[31:0]    = 32'h22;
    step();
    dst_ack_i    = 1'b0;
    dst_update_i = '0;
    check("col ack wins", 128'(qs_of(0)), 128'(32'h11));

    // Timeout: req high exactly 8 cycles, then one-cycle error
    request(2, 3'b100, 32'h1357_9BDF);
    step();
    clear_req();
    wait_req("to");
    n = 0;
    while (dst_req_o && n < 20) begin
      n++;
      step();
    end
    check("to req cycles", 128'(n), 128'(8));
    check("to err", 128'(src_err_o), 128'(4'b0100));
    check("to busy", 128'(src_busy_o), 128'(0));
    check("to held", 128'(qs_of(2)), 128'(32'h1357_9BDF));
    step();
    check("to err pulse", 128'(src_err_o), 128'(0));

    // Ack on the expiry cycle wins
    request(2, 3'b100, 32'h2468_ACE0);
    step();
    clear_req();
    wait_req("ta");
    repeat (7) step();
    check("ta req c8", 128'(dst_req_o), 128'(1));
    dst_ack_i = 1'b1;
    dst_qs_i  = 32'h0BAD_F00D;
    step();
    dst_ack_i = 1'b0;
    check("ta err", 128'(src_err_o), 128'(0));
    check("ta busy", 128'(src_busy_o), 128'(0));
    check("ta qs", 128'(qs_of(2)), 128'(32'h0BAD_F00D));

    // Asynchronous reset while ACTIVE
    request(1, 3'b100, 32'hFEED_0001);
    step();
    clear_req();
    wait_req("ar");
    #2;
    rst_i = 1'b1;
    #1;
    check("ar req", 128'(dst_req_o), 128'(0));
    check("ar wd", 128'(dst_wd_o), 128'(0));
    check("ar busy", 128'(src_busy_o), 128'(0));
    check("ar qs", src_qs_o, RV);
    step();
    rst_i = 1'b0;
    step();
    step();
    check("ar stays idle", 128'(dst_req_o), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
